axis_nibble_assembler: RTL and testbench

//  AXI-Stream slave directly downstream of the clock-packet counter stage. Accepts 3-bit beats,

---
 rtl/axis_nibble_assembler.sv | 195 +++++++++++++++++++
 tb/tb_axis_nibble_assembler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_nibble_assembler.sv
`timescale 1ns/1ps
// Purpose: rebuilds 6-bit packet-count words from two 3-bit AXI-Stream beats (tlast on 2nd), flags framing errors.
// Latency: m_valid rises 1 cycle after the 2nd-beat handshake; 1 word per 2 beats sustained.
// Backpressure: s_tready drops while a word is held with m_ready low (except in DRAIN, which always accepts).
// Optional sequence checker enabled by defining SEQ_CHECK_EN; without it seq_err/seq_err_count are tied to 0.
module axis_nibble_assembler #(
  parameter int BEAT_W = 3,
  parameter int WORD_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [BEAT_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_err,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  err_count,
  input  logic [5:0]        cnt_limit,
  output logic              seq_err,
  output logic [CNT_W-1:0]  seq_err_count
);

  localparam logic [1:0] ST_BEAT0 = 2'd0;
  localparam logic [1:0] ST_BEAT1 = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [BEAT_W-1:0] hi_q, hi_d;
  logic              m_valid_q, m_valid_d;
  logic [WORD_W-1:0] m_data_q, m_data_d;
  logic              m_err_q, m_err_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic              accept;
  logic              deliver;
  logic              load;
  logic              err_evt;
  logic [WORD_W-1:0] asm_word;

  // DRAIN never stalls; otherwise only stall while a held word is not being taken this cycle
  assign s_tready = (state_q == ST_DRAIN) ? 1'b1 : ~(m_valid_q & ~m_ready);
  assign accept   = s_tvalid & s_tready;
  assign deliver  = m_valid_q & m_ready;
  assign asm_word = {hi_q, s_tdata};

  // Framing FSM: decides word loads and short/long-packet errors
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    load    = 1'b0;
    err_evt = 1'b0;
    case (state_q)
      ST_BEAT0: begin
        if (accept) begin
          if (s_tlast) begin
            err_evt = 1'b1;
          end else begin
            hi_d    = s_tdata;
            state_d = ST_BEAT1;
          end
        end
      end
      ST_BEAT1: begin
        if (accept) begin
          if (s_tlast) begin
            load    = 1'b1;
            state_d = ST_BEAT0;
          end else begin
            err_evt = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (accept && s_tlast) begin
          state_d = ST_BEAT0;
        end
      end
      default: state_d = ST_BEAT0;
    endcase
  end

  // Output register: a new load wins over a same-cycle delivery so back-to-back words never bubble
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = asm_word;
    end else if (deliver) begin
      m_valid_d = 1'b0;
    end
  end

  // Saturating counters and the one-cycle framing error pulse
  always_comb begin
    m_err_d   = err_evt;
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (deliver && (pkt_cnt_q != CNT_MAX)) begin
      pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
    end
    if (err_evt && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_BEAT0;
      hi_q      <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_err_q   <= 1'b0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_err_q   <= m_err_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_err     = m_err_q;
  assign pkt_count = pkt_cnt_q;
  assign err_count = err_cnt_q;

`ifdef SEQ_CHECK_EN
  logic              seeded_q, seeded_d;
  logic [WORD_W-1:0] prev_q, prev_d;
  logic [WORD_W-1:0] exp_word;
  logic              seq_err_q, seq_err_d;
  logic [CNT_W-1:0]  seq_cnt_q, seq_cnt_d;

  // Expected next word follows the upstream counter: wraps from cnt_limit back to 1
  assign exp_word = (prev_q == cnt_limit) ? WORD_W'(1) : prev_q + WORD_W'(1);

  // Check each loaded word; first word after reset only seeds, mismatches resync to the received word
  always_comb begin
    seeded_d  = seeded_q;
    prev_d    = prev_q;
    seq_err_d = 1'b0;
    seq_cnt_d = seq_cnt_q;
    if (load) begin
      seeded_d = 1'b1;
      prev_d   = asm_word;
      if (seeded_q && (asm_word != exp_word)) begin
        seq_err_d = 1'b1;
        if (seq_cnt_q != CNT_MAX) begin
          seq_cnt_d = seq_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Sequence checker registers; pulse lines up with the m_valid rise of the offending word
  always_ff @(posedge clk) begin
    if (!rst) begin
      seeded_q  <= 1'b0;
      prev_q    <= '0;
      seq_err_q <= 1'b0;
      seq_cnt_q <= '0;
    end else begin
      seeded_q  <= seeded_d;
      prev_q    <= prev_d;
      seq_err_q <= seq_err_d;
      seq_cnt_q <= seq_cnt_d;
    end
  end

  assign seq_err       = seq_err_q;
  assign seq_err_count = seq_cnt_q;
`else
  logic unused_cnt_limit;
  assign unused_cnt_limit = ^cnt_limit;
  assign seq_err          = 1'b0;
  assign seq_err_count    = '0;
`endif

endmodule

// File: tb/tb_axis_nibble_assembler.sv
`timescale 1ns/1ps
// Bench for axis_nibble_assembler: directed sequences plus a vector table, words tracked by a scoreboard queue.
module tb_axis_nibble_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid;
  logic        s_tready;
  logic [2:0]  s_tdata;
  logic        s_tlast;
  logic        m_valid;
  logic        m_ready;
  logic [5:0]  m_data;
  logic        m_err;
  logic [15:0] pkt_count;
  logic [15:0] err_count;
  logic [5:0]  cnt_limit;
  logic        seq_err;
  logic [15:0] seq_err_count;

  int checks = 0;
  int errors = 0;
  int exp_pkts = 0;
  logic [5:0] sb_q[$];

`ifdef SEQ_CHECK_EN
  localparam logic [31:0] EXP_SEQ = 32'd1;
`else
  localparam logic [31:0] EXP_SEQ = 32'd0;
`endif

  typedef struct {
    logic [2:0] b0;
    logic [2:0] b1;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[6];
  vec_t seqv[4];

  always #5 clk = ~clk;

  axis_nibble_assembler dut (
    .clk           (clk),
    .rst           (rst),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .s_tdata       (s_tdata),
    .s_tlast       (s_tlast),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_err         (m_err),
    .pkt_count     (pkt_count),
    .err_count     (err_count),
    .cnt_limit     (cnt_limit),
    .seq_err       (seq_err),
    .seq_err_count (seq_err_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until the DUT takes it (bounded wait)
  task automatic send_beat(input logic [2:0] d, input logic l);
    int  n;
    bit  done;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (s_tready === 1'b1) begin
        done = 1'b1;
      end else begin
        n++;
        if (n > 100) begin
          checks++;
          errors++;
          $display("FAIL beat_accept_timeout: s_tready stayed %b", s_tready);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_word(input logic [2:0] a, input logic [2:0] b, input logic [5:0] exp);
    send_beat(a, 1'b0);
    sb_q.push_back(exp);
    send_beat(b, 1'b1);
  endtask

  // Scoreboard: a handshake seen here completes on the following posedge
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_word: got %0h, expected no word", m_data);
      end else begin
        chk("sb_word", {26'd0, m_data}, {26'd0, sb_q.pop_front()});
        exp_pkts++;
      end
    end
  end

  initial begin
    vecs[0] = '{3'o1, 3'o0, 6'o10};
    vecs[1] = '{3'o7, 3'o0, 6'o70};
    vecs[2] = '{3'o0, 3'o7, 6'o07};
    vecs[3] = '{3'o5, 3'o2, 6'o52};
    vecs[4] = '{3'o3, 3'o6, 6'o36};
    vecs[5] = '{3'o4, 3'o4, 6'o44};
    seqv[0] = '{3'o0, 3'o1, 6'o01};
    seqv[1] = '{3'o0, 3'o2, 6'o02};
    seqv[2] = '{3'o0, 3'o3, 6'o03};
    seqv[3] = '{3'o0, 3'o1, 6'o01};

    rst       = 1'b0;
    s_tvalid  = 1'b0;
    s_tdata   = 3'o0;
    s_tlast   = 1'b0;
    m_ready   = 1'b1;
    cnt_limit = 6'd3;
    idle(2);
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_m_data", {26'd0, m_data}, 0);
    chk("rst_pkt_count", {16'd0, pkt_count}, 0);
    chk("rst_err_count", {16'd0, err_count}, 0);
    rst = 1'b1;
    idle(1);

    // 1: basic pair
    send_word(3'o2, 3'o5, 6'o25);
    chk("t1_m_valid", {31'd0, m_valid}, 1);
    chk("t1_m_data", {26'd0, m_data}, 32'o25);
    idle(1);
    chk("t1_pkt_count", {16'd0, pkt_count}, 1);
    chk("t1_m_valid_clear", {31'd0, m_valid}, 0);

    // 2: downstream stall holds the word and blocks beats
    m_ready = 1'b0;
    send_word(3'o1, 3'o4, 6'o14);
    chk("t2_m_valid", {31'd0, m_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_s_tready_low", {31'd0, s_tready}, 0);
      chk("t2_m_data_hold", {26'd0, m_data}, 32'o14);
      idle(1);
    end
    m_ready = 1'b1;
    idle(1);
    chk("t2_pkt_count", {16'd0, pkt_count}, 2);
    chk("t2_s_tready_back", {31'd0, s_tready}, 1);
    chk("t2_m_valid_clear", {31'd0, m_valid}, 0);

    // Vector table, back-to-back words
    for (int i = 0; i < 6; i++) begin
      send_word(vecs[i].b0, vecs[i].b1, vecs[i].exp);
      chk("vec_m_valid", {31'd0, m_valid}, 1);
      chk("vec_m_data", {26'd0, m_data}, {26'd0, vecs[i].exp});
    end
    idle(2);
    chk("vec_pkt_count", {16'd0, pkt_count}, 8);

    // 3: short packet
    send_beat(3'o4, 1'b1);
    chk("t3_m_err", {31'd0, m_err}, 1);
    chk("t3_err_count", {16'd0, err_count}, 1);
    chk("t3_no_word", {31'd0, m_valid}, 0);
    idle(1);
    chk("t3_m_err_pulse", {31'd0, m_err}, 0);
    send_word(3'o6, 3'o3, 6'o63);
    chk("t3_recover", {26'd0, m_data}, 32'o63);

    // 4: long packet, one error only, then recovery
    send_beat(3'o1, 1'b0);
    send_beat(3'o2, 1'b0);
    chk("t4_m_err", {31'd0, m_err}, 1);
    chk("t4_err_count", {16'd0, err_count}, 2);
    send_beat(3'o3, 1'b0);
    chk("t4_drain_no_err", {31'd0, m_err}, 0);
    send_beat(3'o4, 1'b1);
    chk("t4_err_count_once", {16'd0, err_count}, 2);
    chk("t4_no_word", {31'd0, m_valid}, 0);
    send_word(3'o0, 3'o1, 6'o01);
    chk("t4_recover", {26'd0, m_data}, 32'o01);
    idle(2);
    chk("t4_pkt_count", {16'd0, pkt_count}, 10);

    // 6: reset mid-packet
    send_beat(3'o6, 1'b0);
    rst = 1'b0;
    idle(1);
    sb_q.delete();
    exp_pkts = 0;
    chk("t6_m_valid", {31'd0, m_valid}, 0);
    chk("t6_m_data", {26'd0, m_data}, 0);
    chk("t6_m_err", {31'd0, m_err}, 0);
    chk("t6_pkt_count", {16'd0, pkt_count}, 0);
    chk("t6_err_count", {16'd0, err_count}, 0);
    chk("t6_seq_err_count", {16'd0, seq_err_count}, 0);
    chk("t6_s_tready", {31'd0, s_tready}, 1);
    rst = 1'b1;
    send_word(3'o7, 3'o7, 6'o77);
    chk("t6_word", {26'd0, m_data}, 32'o77);
    idle(1);
    chk("t6_pkt_after", {16'd0, pkt_count}, 1);
    chk("t6_err_after", {16'd0, err_count}, 0);

    // 5: sequence checking with cnt_limit=3
    rst = 1'b0;
    idle(1);
    sb_q.delete();
    exp_pkts = 0;
    rst = 1'b1;
    cnt_limit = 6'd3;
    for (int i = 0; i < 4; i++) begin
      send_word(seqv[i].b0, seqv[i].b1, seqv[i].exp);
      chk("t5_seq_ok", {31'd0, seq_err}, 0);
    end
    chk("t5_seq_count_zero", {16'd0, seq_err_count}, 0);
    send_word(3'o0, 3'o3, 6'o03);
    chk("t5_seq_err_pulse", {31'd0, seq_err}, EXP_SEQ);
    chk("t5_word_unchanged", {26'd0, m_data}, 32'o03);
    idle(1);
    chk("t5_seq_err_clear", {31'd0, seq_err}, 0);
    chk("t5_seq_count", {16'd0, seq_err_count}, EXP_SEQ);
    send_word(3'o0, 3'o1, 6'o01);
    chk("t5_resync", {31'd0, seq_err}, 0);

    idle(3);
    chk("end_sb_empty", sb_q.size(), 0);
    chk("end_pkt_count", {16'd0, pkt_count}, 32'd6);
    chk("end_pkt_model", {16'd0, pkt_count}, exp_pkts);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
